sram_like_arbiter: RTL and testbench
====================================

# sram_like_arbiter

Parametrised N-channel arbiter that merges the CPU's independent memory request streams (instruction fetch, data load/store, later uncached/DMA ports) onto one shared sram-like port with a request/addr_ok/data_ok handshake. It replaces the fixed always-enabled instruction and data SRAM wiring at the CPU top. It adds fixed-priority or round-robin arbitration, byte-strobe generation from access size, and variable-latency memory support. One transaction is outstanding at a time.

## Interface
- NCH, 2: number of requesting channels (≥2); channel 0 = data port, channel 1 = instruction port.
- AW, 32: address width.
- RR, 0: 0 = fixed priority (lowest index wins); 1 = round-robin.
- clk  in  1  system clock; single clock domain.
- resetn  in  1  asynchronous, active-low reset.
- ch_req  in  NCH  per-channel request, held until ch_addr_ok.
- ch_wr  in  NCH  1 = write, 0 = read.
- ch_size  in  2*NCH  0 = byte, 1 = half, 2 = word, 3 treated as word.
- ch_addr  in  AW*NCH  byte address.
- ch_wdata  in  32*NCH  write data, already lane-aligned.
- ch_addr_ok  out  NCH  one-hot pulse; request captured this cycle.
- ch_data_ok  out  NCH  one-hot pulse; read data valid or write done.
- ch_rdata  out  32  read data, broadcast to all channels.
- mem_req  out  1  shared-port request.
- mem_wr  out  1  shared-port write flag.
- mem_wstrb  out  4  byte strobes; meaningful for writes and reads.
- mem_addr  out  AW  shared-port address.
- mem_wdata  out  32  shared-port write data.
- mem_addr_ok  in  1  memory accepted the request.
- mem_data_ok  in  1  memory data/ack; never in the same cycle as its own mem_addr_ok.
- mem_rdata  in  32  memory read data.

## Operation
- FSM states: IDLE, ADDR, DATA.
- Capture conditions: the state is IDLE, or the state is DATA and mem_data_ok is high, and at least one ch_req is high.
  - On capture, the winning channel's wr/size/addr/wdata and its index go into holding registers.
  - ch_addr_ok[win] is high that cycle.
  - The next state is ADDR.
- ADDR: mem_req=1, driven from the holding registers. On mem_addr_ok the FSM goes to DATA. mem_data_ok is ignored in ADDR.
- DATA: mem_req=0. On mem_data_ok:
  - ch_data_ok[granted] pulses.
  - If a new capture happens the same cycle, the FSM goes to ADDR; otherwise it goes to IDLE.
- Fixed priority: the lowest set ch_req index wins.
- Round-robin: the search starts at the last granted index + 1, modulo NCH. The pointer updates only on capture and resets to NCH-1, so channel 0 wins first.
- Strobes:
  - size 0: 4'b0001 << addr[1:0]
  - size 1: 4'b0011 << {addr[1],1'b0}
  - size 2/3: 4'hF
- Misaligned half/word accesses are not checked (the upstream exception logic does that). Strobes follow the formula and ignore the low bits not used by it.
- mem_addr is passed unmodified.
- ch_rdata = mem_rdata, combinational.
- ch_addr_ok and ch_data_ok are combinational from the state, ch_req and mem_data_ok, and are never high for more than one channel.

## Timing
- Reset values: mem_req/mem_wr 0, mem_wstrb 0, mem_addr 0, mem_wdata 0, all ch_addr_ok/ch_data_ok 0. The FSM is in IDLE and the RR pointer is NCH-1.
- Capture cycle T: ch_addr_ok. From T+1, mem_req is high until mem_addr_ok.
- Minimum request-to-data_ok latency is 3 cycles with zero-wait memory (T capture, T+1 addr_ok, T+2 data_ok).
- Back-to-back throughput is one transaction per 2 cycles.
- Simultaneous requests: exactly one is granted; losers keep ch_req high and see no ch_addr_ok.
- A channel dropping ch_req without ch_addr_ok is legal and cancels that request.
- Reset asserted mid-transaction: the FSM goes to IDLE immediately and mem_req drops asynchronously. The pending transaction is lost with no data_ok; the memory is reset by the same resetn.

## Structure
- The shared package holds:
  - state enum (IDLE/ADDR/DATA);
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - the strobe function.
- Sub-module rr_picker (NCH, RR): request vector plus pointer in, one-hot grant plus index out; purely combinational.
- Everything else lives in sram_like_arbiter.

## Test plan
- Single read, NCH=2, ch1 reads addr 0xBFC00000 size 2:
  - ch_addr_ok[1] in the capture cycle;
  - mem_req the next cycle with mem_wstrb=4'hF;
  - memory returns 0x3C1D0001 two cycles later;
  - ch_data_ok[1] pulses with ch_rdata=0x3C1D0001.
- Fixed priority, ch0 and ch1 both request every cycle:
  - ch0 is granted on every capture;
  - ch1 gets ch_addr_ok only when ch0 drops req.
- RR=1, NCH=3, all three request continuously:
  - grants go 0,1,2,0,1,2;
  - no channel starves.
- Byte store, ch0 write size 0, addr 0x80000003, wdata 0xAA000000:
  - mem_wstrb=4'b1000, mem_wr=1, mem_wdata=0xAA000000.
- Wait-state memory, mem_addr_ok delayed 3 cycles and mem_data_ok 4 cycles after that:
  - mem_req and address stay stable through the wait;
  - exactly one ch_data_ok is produced.
- resetn pulsed low while in DATA:
  - mem_req=0 immediately and no ch_data_ok;
  - after release, a fresh request completes normally.

Source files
------------

// File: rtl/sram_like_arbiter_pkg.sv
// Shared types and helpers for the sram-like port arbiter.
// State encoding, access-size codes and the size-to-strobe mapping.
package sram_like_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  // Low address bits beyond what the size needs are ignored; misalignment is caught upstream.
  function automatic logic [3:0] size_strb(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SZ_BYTE: size_strb = 4'b0001 << addr_lo;
      SZ_HALF: size_strb = 4'b0011 << {addr_lo[1], 1'b0};
      default: size_strb = 4'hF;
    endcase
  endfunction

endpackage

// File: rtl/sram_like_arbiter_rr_picker.sv
// Combinational request picker: lowest index first, or rotating search starting after ptr.
// Produces a one-hot grant and the matching index.
module sram_like_arbiter_rr_picker #(
  parameter int NCH = 2,
  parameter int RR  = 0,
  parameter int IW  = $clog2(NCH)
) (
  input  logic [NCH-1:0] req,
  input  logic [IW-1:0]  ptr,
  output logic [NCH-1:0] grant,
  output logic [IW-1:0]  idx,
  output logic           any
);

  logic          found;
  logic [IW-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    found = 1'b0;
    cand  = '0;
    for (int i = 0; i < NCH; i++) begin
      if (RR != 0) cand = IW'((int'(ptr) + 1 + i) % NCH);
      else         cand = IW'(i);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/sram_like_arbiter.sv
// N-channel arbiter merging independent request streams onto one sram-like port.
// One transaction outstanding; a new capture may overlap the previous data_ok.
//
//   state | meaning
//   IDLE  | no transaction; capture any request
//   ADDR  | mem_req high from holding regs until mem_addr_ok
//   DATA  | waiting for mem_data_ok; may capture next request that cycle
module sram_like_arbiter
  import sram_like_arbiter_pkg::*;
#(
  parameter int NCH = 2,
  parameter int AW  = 32,
  parameter int RR  = 0
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [NCH-1:0]    ch_req,
  input  logic [NCH-1:0]    ch_wr,
  input  logic [2*NCH-1:0]  ch_size,
  input  logic [AW*NCH-1:0] ch_addr,
  input  logic [32*NCH-1:0] ch_wdata,
  output logic [NCH-1:0]    ch_addr_ok,
  output logic [NCH-1:0]    ch_data_ok,
  output logic [31:0]       ch_rdata,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [3:0]        mem_wstrb,
  output logic [AW-1:0]     mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_addr_ok,
  input  logic              mem_data_ok,
  input  logic [31:0]       mem_rdata
);

  localparam int IW = $clog2(NCH);

  state_t          state, state_nxt;
  logic [NCH-1:0]  grant;
  logic [IW-1:0]   win, ptr, h_idx;
  logic            any, done, capture;
  logic [1:0]      sel_size;
  logic [AW-1:0]   sel_addr;
  logic [31:0]     sel_wdata;

  sram_like_arbiter_rr_picker #(.NCH(NCH), .RR(RR), .IW(IW)) u_pick (
    .req   (ch_req),
    .ptr   (ptr),
    .grant (grant),
    .idx   (win),
    .any   (any)
  );

  assign sel_size  = ch_size[win*2 +: 2];
  assign sel_addr  = ch_addr[win*AW +: AW];
  assign sel_wdata = ch_wdata[win*32 +: 32];

  assign done     = (state == DATA) && mem_data_ok;
  assign capture  = ((state == IDLE) || done) && any;
  assign ch_rdata = mem_rdata;

  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    ch_addr_ok = '0;
    ch_data_ok = '0;
    if (capture) ch_addr_ok = grant;
    if (done)    ch_data_ok = {{(NCH-1){1'b0}}, 1'b1} << h_idx;
    case (state)
      IDLE: if (capture) state_nxt = ADDR;
      ADDR: begin
        mem_req = 1'b1;
        if (mem_addr_ok) state_nxt = DATA;
      end
      DATA: if (done) state_nxt = capture ? ADDR : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      ptr       <= IW'(NCH - 1);
      h_idx     <= '0;
      mem_wr    <= 1'b0;
      mem_wstrb <= 4'h0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (capture) begin
        ptr       <= win;
        h_idx     <= win;
        mem_wr    <= ch_wr[win];
        mem_wstrb <= size_strb(sel_size, sel_addr[1:0]);
        mem_addr  <= sel_addr;
        mem_wdata <= sel_wdata;
      end
    end
  end

endmodule

// File: tb/tb_sram_like_arbiter.sv
// Directed bench: fixed-priority 2-channel instance and round-robin 3-channel instance,
// each behind a small wait-state memory responder.
module tb_sram_like_arbiter;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  a_req = '0, a_wr = '0, a_aok, a_dok;
  logic [3:0]  a_size = '0;
  logic [63:0] a_addr = '0, a_wdata = '0;
  logic [31:0] a_rdata;

  logic [2:0]  b_req = '0, b_wr = '0, b_aok, b_dok;
  logic [5:0]  b_size = 6'b101010;
  logic [95:0] b_addr = {32'h300, 32'h200, 32'h100}, b_wdata = '0;
  logic [31:0] b_rdata;

  logic        m_req [2];
  logic        m_wr [2];
  logic [3:0]  m_wstrb [2];
  logic [31:0] m_addr [2];
  logic [31:0] m_wdata [2];
  logic        m_aok [2] = '{1'b0, 1'b0};
  logic        m_dok [2] = '{1'b0, 1'b0};
  logic [31:0] m_rdata [2] = '{32'h0, 32'h0};

  int          aw [2] = '{0, 0};
  int          dw [2] = '{0, 0};
  int          acnt [2] = '{0, 0};
  int          dcnt [2] = '{0, 0};
  bit          pend [2] = '{1'b0, 1'b0};
  logic [31:0] rd_val [2] = '{32'h0, 32'h0};

  int n_vec = 0, n_err = 0;

  sram_like_arbiter #(.NCH(2), .AW(32), .RR(0)) u_dut_a (
    .clk(clk), .resetn(resetn),
    .ch_req(a_req), .ch_wr(a_wr), .ch_size(a_size), .ch_addr(a_addr), .ch_wdata(a_wdata),
    .ch_addr_ok(a_aok), .ch_data_ok(a_dok), .ch_rdata(a_rdata),
    .mem_req(m_req[0]), .mem_wr(m_wr[0]), .mem_wstrb(m_wstrb[0]), .mem_addr(m_addr[0]),
    .mem_wdata(m_wdata[0]), .mem_addr_ok(m_aok[0]), .mem_data_ok(m_dok[0]), .mem_rdata(m_rdata[0])
  );

  sram_like_arbiter #(.NCH(3), .AW(32), .RR(1)) u_dut_b (
    .clk(clk), .resetn(resetn),
    .ch_req(b_req), .ch_wr(b_wr), .ch_size(b_size), .ch_addr(b_addr), .ch_wdata(b_wdata),
    .ch_addr_ok(b_aok), .ch_data_ok(b_dok), .ch_rdata(b_rdata),
    .mem_req(m_req[1]), .mem_wr(m_wr[1]), .mem_wstrb(m_wstrb[1]), .mem_addr(m_addr[1]),
    .mem_wdata(m_wdata[1]), .mem_addr_ok(m_aok[1]), .mem_data_ok(m_dok[1]), .mem_rdata(m_rdata[1])
  );

  // Responder: addr_ok after aw waiting cycles, data_ok dw cycles after entering DATA.
  task automatic mem_step(input int k);
    m_aok[k] = 1'b0;
    m_dok[k] = 1'b0;
    if (!resetn) begin
      pend[k] = 1'b0; acnt[k] = 0; dcnt[k] = 0;
    end else if (pend[k]) begin
      if (dcnt[k] == dw[k]) begin
        m_dok[k] = 1'b1; m_rdata[k] = rd_val[k]; pend[k] = 1'b0; dcnt[k] = 0;
      end else dcnt[k]++;
    end else if (m_req[k]) begin
      if (acnt[k] == aw[k]) begin
        m_aok[k] = 1'b1; pend[k] = 1'b1; acnt[k] = 0;
      end else acnt[k]++;
    end
  endtask

  initial forever begin
    @(negedge clk);
    mem_step(0);
    mem_step(1);
  end

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_dok_a(input logic [1:0] exp, input string tag, input int lim);
    for (int i = 0; i < lim; i++) begin
      step();
      #1;
      if (a_dok != 2'b00) break;
    end
    chk_vec(tag, 32'(a_dok), 32'(exp));
  endtask

  task automatic read_a1(input logic [31:0] addr, input logic [31:0] data, input string tag);
    step();
    rd_val[0] = data;
    a_req = 2'b10; a_wr = 2'b00; a_size[3:2] = 2'd2; a_addr[63:32] = addr;
    #1;
    chk_vec({tag, "_aok"}, 32'(a_aok), 32'h2);
    step();
    a_req = 2'b00;
    #1;
    chk_vec({tag, "_mreq"}, 32'(m_req[0]), 32'h1);
    chk_vec({tag, "_maddr"}, m_addr[0], addr);
    wait_dok_a(2'b10, {tag, "_dok"}, 20);
    chk_vec({tag, "_rdata"}, a_rdata, data);
  endtask

  int ncap, nreq, ndok;

  initial begin
    #2;
    chk_vec("rst_mreq", 32'(m_req[0]), 32'h0);
    chk_vec("rst_mwr", 32'(m_wr[0]), 32'h0);
    chk_vec("rst_wstrb", 32'(m_wstrb[0]), 32'h0);
    chk_vec("rst_maddr", m_addr[0], 32'h0);
    chk_vec("rst_mwdata", m_wdata[0], 32'h0);
    chk_vec("rst_oks", {28'h0, a_aok, a_dok}, 32'h0);
    step(); step();
    resetn = 1'b1;

    // Single read, zero-wait: capture, addr_ok next cycle, data_ok the one after
    step();
    rd_val[0] = 32'h3C1D0001;
    a_req = 2'b10; a_size[3:2] = 2'd2; a_addr[63:32] = 32'hBFC00000;
    #1;
    chk_vec("rd_aok", 32'(a_aok), 32'h2);
    step();
    a_req = 2'b00;
    #1;
    chk_vec("rd_mreq", 32'(m_req[0]), 32'h1);
    chk_vec("rd_wstrb", 32'(m_wstrb[0]), 32'hF);
    chk_vec("rd_maddr", m_addr[0], 32'hBFC00000);
    chk_vec("rd_mwr", 32'(m_wr[0]), 32'h0);
    chk_vec("rd_aok_off", 32'(a_aok), 32'h0);
    step();
    #1;
    chk_vec("rd_dok", 32'(a_dok), 32'h2);
    chk_vec("rd_rdata", a_rdata, 32'h3C1D0001);
    step();
    #1;
    chk_vec("rd_idle_dok", 32'(a_dok), 32'h0);
    chk_vec("rd_idle_mreq", 32'(m_req[0]), 32'h0);

    // Fixed priority with both channels requesting: ch0 on every capture, one per 2 cycles
    step();
    a_req = 2'b11; a_size = 4'b1010; a_addr = {32'h00001004, 32'h00002000};
    ncap = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      if (a_aok != 2'b00) begin
        chk_vec("fp_grant", 32'(a_aok), 32'h1);
        ncap++;
      end
      step();
    end
    chk_vec("fp_ncap", ncap, 4);
    a_req = 2'b10;
    #1;
    for (int i = 0; i < 6; i++) begin
      if (a_aok != 2'b00) break;
      step();
      #1;
    end
    chk_vec("fp_ch1", 32'(a_aok), 32'h2);
    step();
    a_req = 2'b00;
    #1;
    chk_vec("fp_ch1_addr", m_addr[0], 32'h00001004);
    wait_dok_a(2'b10, "fp_ch1_dok", 10);

    // Byte and half stores on ch0
    step();
    a_req = 2'b01; a_wr = 2'b01; a_size[1:0] = 2'd0;
    a_addr[31:0] = 32'h80000003; a_wdata[31:0] = 32'hAA000000;
    #1;
    chk_vec("sb_aok", 32'(a_aok), 32'h1);
    step();
    a_req = 2'b00;
    #1;
    chk_vec("sb_mwr", 32'(m_wr[0]), 32'h1);
    chk_vec("sb_wstrb", 32'(m_wstrb[0]), 32'h8);
    chk_vec("sb_wdata", m_wdata[0], 32'hAA000000);
    chk_vec("sb_maddr", m_addr[0], 32'h80000003);
    wait_dok_a(2'b01, "sb_dok", 10);
    step();
    a_req = 2'b01; a_size[1:0] = 2'd1; a_addr[31:0] = 32'h80000002; a_wdata[31:0] = 32'h12340000;
    #1;
    step();
    a_req = 2'b00;
    #1;
    chk_vec("sh_wstrb", 32'(m_wstrb[0]), 32'hC);
    wait_dok_a(2'b01, "sh_dok", 10);
    a_wr = 2'b00;

    // Wait-state memory: mem_req and address held through 3 wait cycles, single data_ok
    aw[0] = 3; dw[0] = 4;
    step();
    a_req = 2'b10; a_addr[63:32] = 32'hA0001000;
    #1;
    chk_vec("ws_aok", 32'(a_aok), 32'h2);
    nreq = 0; ndok = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      a_req = 2'b00;
      #1;
      if (m_req[0]) begin
        nreq++;
        chk_vec("ws_addr_hold", m_addr[0], 32'hA0001000);
      end
      if (a_dok != 2'b00) ndok++;
    end
    chk_vec("ws_nreq", nreq, 4);
    chk_vec("ws_ndok", ndok, 1);

    // Reset while waiting for addr_ok: mem_req must drop without a clock edge
    aw[0] = 5; dw[0] = 0;
    step();
    a_req = 2'b10; a_addr[63:32] = 32'hC0000010;
    step();
    a_req = 2'b00;
    #1;
    chk_vec("ra_mreq_pre", 32'(m_req[0]), 32'h1);
    resetn = 1'b0;
    #1;
    chk_vec("ra_mreq_async", 32'(m_req[0]), 32'h0);
    step();
    resetn = 1'b1;

    // Reset while in DATA: transaction lost, no data_ok, then a clean read
    aw[0] = 0; dw[0] = 5;
    step();
    a_req = 2'b10; a_addr[63:32] = 32'hC0000020;
    step();
    a_req = 2'b00;
    step();
    #1;
    resetn = 1'b0;
    #1;
    chk_vec("rd_rst_mreq", 32'(m_req[0]), 32'h0);
    chk_vec("rd_rst_maddr", m_addr[0], 32'h0);
    ndok = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (i == 3) resetn = 1'b1;
      #1;
      if (a_dok != 2'b00) ndok++;
    end
    chk_vec("rd_rst_no_dok", ndok, 0);
    dw[0] = 0;
    read_a1(32'hBFC00010, 32'h5A5A0F0F, "post_rst");

    // Round robin, three channels always requesting
    step();
    b_req = 3'b111;
    ncap = 0;
    for (int i = 0; i < 12; i++) begin
      #1;
      if (b_aok != 3'b000) begin
        chk_vec("rr_grant", 32'(b_aok), 32'(3'b001 << (ncap % 3)));
        ncap++;
      end
      step();
    end
    b_req = 3'b000;
    chk_vec("rr_ncap", ncap, 6);
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
